// File: rtl/ttl_regfile_574.sv
// ttl_regfile_574: DEPTH x WIDTH register bank with one synchronous write port
// and one registered read port. The read port loads an output latch on every
// clock, and that latch drives a shared bus through an active-low tri-state
// enable.
module ttl_regfile_574 #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = 2,
    parameter int BYPASS     = 0,
    parameter int DELAY_RISE = 7,
    parameter int DELAY_FALL = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Write_bar,
    input  logic [AW-1:0]    WAddr,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RAddr,
    input  logic             Output_bar,
    output logic [WIDTH-1:0] Q,
    output logic             Valid
);

    // One extra bit so that DEPTH == 2**AW can still be represented.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    // The zero initial values make simulation start clean, before the first reset.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic             vld [DEPTH] = '{default: 1'b0};
    logic [WIDTH-1:0] latch       = '0;
    logic             valid_q     = 1'b0;

    logic             wr_en;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    // Decode the write and the read address. An X or Z on Write_bar makes
    // wr_en unknown, and the sequential 'if' below then treats it as no write.
    always_comb begin
        wr_en = (Write_bar == 1'b0) && ({1'b0, WAddr} < DEPTH_LIM);
        rd_ok = ({1'b0, RAddr} < DEPTH_LIM);
    end

    // Choose the value the output latch loads at the next edge. An
    // out-of-range read gives 0 and not valid. A colliding write is forwarded
    // only when BYPASS is set.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a value held and infer a latch.
        rd_data  = '0;
        rd_valid = 1'b0;
        if (rd_ok) begin
            if ((BYPASS != 0) && wr_en && (WAddr == RAddr)) begin
                rd_data  = D;
                rd_valid = 1'b1;
            end else begin
                rd_data  = mem[RAddr];
                rd_valid = vld[RAddr];
            end
        end
    end

    // Storage, per-entry valid bits and the output latch. Reset wins over a
    // write on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let the read see the pre-write entry on a same-edge collision.
        if (reset) begin
            // NOTE: each entry is cleared on purpose because valid tracking needs it; a bank this small stays in flops.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                vld[i] <= 1'b0;
            end
            latch   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[WAddr] <= D;
                vld[WAddr] <= 1'b1;
            end
            latch   <= rd_data;
            valid_q <= rd_valid;
        end
    end

    assign Valid = valid_q;

    // Asynchronous bus driver, modelled with the part's propagation delays.
    assign #(DELAY_RISE, DELAY_FALL) Q = Output_bar ? {WIDTH{1'bz}} : latch;

endmodule

// File: tb/tb_ttl_regfile_574.sv
// tb_ttl_regfile_574: drives three copies of the register bank with the same
// stimulus. The copies are DEPTH=4 without bypass, DEPTH=4 with bypass, and
// DEPTH=3 without bypass. Each copy is compared against an array-based model
// of the bank, and a set of literal expectations pins that model.
module tb_ttl_regfile_574;

    logic       clk;
    logic       reset;
    logic       write_bar;
    logic [1:0] waddr;
    logic [7:0] d;
    logic [1:0] raddr;
    logic       output_bar;
    wire  [7:0] q0, q1, q2;
    wire        v0, v1, v2;

    ttl_regfile_574 #(.WIDTH(8), .DEPTH(4), .AW(2), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .Write_bar(write_bar), .WAddr(waddr), .D(d),
        .RAddr(raddr), .Output_bar(output_bar), .Q(q0), .Valid(v0));

    ttl_regfile_574 #(.WIDTH(8), .DEPTH(4), .AW(2), .BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .Write_bar(write_bar), .WAddr(waddr), .D(d),
        .RAddr(raddr), .Output_bar(output_bar), .Q(q1), .Valid(v1));

    ttl_regfile_574 #(.WIDTH(8), .DEPTH(3), .AW(2), .BYPASS(0)) dut2 (
        .clk(clk), .reset(reset), .Write_bar(write_bar), .WAddr(waddr), .D(d),
        .RAddr(raddr), .Output_bar(output_bar), .Q(q2), .Valid(v2));

    // Model state, one row per DUT copy.
    logic [7:0] m_mem [3][4];
    logic       m_vld [3][4];
    logic [7:0] m_lat [3];
    logic       m_v   [3];
    logic       oe_pause;

    int n_checks;
    int n_fail;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int c);
        return (c == 2) ? 3 : 4;
    endfunction

    // Update the model with the result of the edge that just sampled the inputs.
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (reset) begin
                for (int e = 0; e < 4; e++) begin
                    m_mem[c][e] = 8'h00;
                    m_vld[c][e] = 1'b0;
                end
                m_lat[c] = 8'h00;
                m_v[c]   = 1'b0;
            end else begin
                int  dp;
                bit  wr;
                dp = depth_of(c);
                wr = (write_bar == 1'b0) && (int'(waddr) < dp);
                if (int'(raddr) >= dp) begin
                    m_lat[c] = 8'h00;
                    m_v[c]   = 1'b0;
                end else if (c == 1 && wr && waddr == raddr) begin
                    m_lat[c] = d;
                    m_v[c]   = 1'b1;
                end else begin
                    m_lat[c] = m_mem[c][raddr];
                    m_v[c]   = m_vld[c][raddr];
                end
                if (wr) begin
                    m_mem[c][waddr] = d;
                    m_vld[c][waddr] = 1'b1;
                end
            end
        end
    endtask

    // Apply one cycle of inputs. This is the only place a posedge is consumed.
    task automatic drive(input logic rst, input logic wb, input logic [1:0] wa,
                         input logic [7:0] wd, input logic [1:0] ra);
        reset     = rst;
        write_bar = wb;
        waddr     = wa;
        d         = wd;
        raddr     = ra;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Move to a point where Q has settled after the last edge.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Compare every DUT copy against the model on every falling edge.
    always @(negedge clk) begin
        if (!oe_pause) begin
            check("valid0", v0, m_v[0]);
            check("valid1", v1, m_v[1]);
            check("valid2", v2, m_v[2]);
            if (output_bar == 1'b0) begin
                check("q0", q0, m_lat[0]);
                check("q1", q1, m_lat[1]);
                check("q2", q2, m_lat[2]);
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        oe_pause   = 1'b0;
        output_bar = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int e = 0; e < 4; e++) begin
                m_mem[c][e] = 8'h00;
                m_vld[c][e] = 1'b0;
            end
            m_lat[c] = 8'h00;
            m_v[c]   = 1'b0;
        end

        // Reset, then read every entry of a cleared bank.
        drive(1'b1, 1'b1, 2'd0, 8'h00, 2'd0);
        settle();
        check("reset_q", q0, 8'h00);
        check("reset_valid", v0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b1, 2'd0, 8'h00, 2'(a));
            settle();
            check("cleared_q", q0, 8'h00);
            check("cleared_valid", v0, 1'b0);
        end

        // Basic writes and reads.
        drive(1'b0, 1'b0, 2'd0, 8'hA5, 2'd1);
        drive(1'b0, 1'b0, 2'd3, 8'h3C, 2'd1);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd3);
        settle();
        check("rd3_q", q0, 8'h3C);
        check("rd3_valid", v0, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd0);
        settle();
        check("rd0_q", q0, 8'hA5);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd1);
        settle();
        check("rd1_valid", v0, 1'b0);

        // A write and a read to the same address on the same edge.
        drive(1'b0, 1'b0, 2'd2, 8'h11, 2'd0);
        drive(1'b0, 1'b0, 2'd2, 8'h22, 2'd2);
        settle();
        check("collide_nobyp_q", q0, 8'h11);
        check("collide_byp_q", q1, 8'h22);
        check("collide_byp_valid", v1, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd2);
        settle();
        check("after_collide_q", q0, 8'h22);

        // Output enable toggled between clock edges.
        drive(1'b0, 1'b0, 2'd1, 8'h5A, 2'd0);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd1);
        settle();
        check("latched_5a", q0, 8'h5A);
        oe_pause   = 1'b1;
        output_bar = 1'b1;
        #8;
        check("oe_off_released", (q0 !== 8'h5A), 1'b1);
        check("oe_off_valid", v0, 1'b1);
        output_bar = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd1);
        #6;
        check("oe_on_q", q0, 8'h5A);
        check("oe_on_valid", v0, 1'b1);
        oe_pause = 1'b0;

        // Reset and a write on the same edge: the write is lost.
        drive(1'b1, 1'b0, 2'd2, 8'hFF, 2'd0);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd2);
        settle();
        check("rst_beats_wr_q", q0, 8'h00);
        check("rst_beats_wr_valid", v0, 1'b0);

        // Reset in the middle of a run of writes.
        drive(1'b0, 1'b0, 2'd0, 8'h12, 2'd0);
        drive(1'b0, 1'b0, 2'd1, 8'h34, 2'd0);
        drive(1'b0, 1'b0, 2'd3, 8'h56, 2'd0);
        drive(1'b1, 1'b1, 2'd0, 8'h00, 2'd0);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd1);
        settle();
        check("midrst_q", q0, 8'h00);
        check("midrst_valid", v0, 1'b0);

        // Address 3 is beyond the end of the DEPTH=3 copy.
        drive(1'b0, 1'b0, 2'd3, 8'h77, 2'd0);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 2'd3);
        settle();
        check("d3_oob_q", q2, 8'h00);
        check("d3_oob_valid", v2, 1'b0);
        check("d4_addr3_q", q0, 8'h77);
        check("d4_addr3_valid", v0, 1'b1);

        // Random traffic. About a quarter of the reads are aimed at the
        // address being written in the same cycle.
        for (int n = 0; n < 400; n++) begin
            logic       r_rst, r_wb;
            logic [1:0] r_wa, r_ra;
            logic [7:0] r_d;
            r_rst = ($urandom_range(0, 39) == 0);
            r_wb  = 1'($urandom_range(0, 1));
            r_wa  = 2'($urandom_range(0, 3));
            r_d   = 8'($urandom);
            r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 2'($urandom_range(0, 3));
            drive(r_rst, r_wb, r_wa, r_d, r_ra);
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
